// File: rtl/reg_dump_tx_pkg.sv
// reg_dump_tx_pkg: FSM state encodings and serial frame levels shared by the register dump transmitter.
package reg_dump_tx_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/reg_dump_tx_baud_tick_gen.sv
// baud_tick_gen: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks the register bank read port and sends each register as a UART frame on tx.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int NUM_REGS     = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, ra_q, ra_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic              tick, enter;
    assign enter = state_d != state_q;
    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (enter),
        .tick_o(tick)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_START;
            S_START: if (tick) state_d = S_DATA;
            S_DATA:  if (tick && bit_q == LAST_BIT) state_d = S_STOP;
            S_STOP: begin
                if (tick) begin
                    state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
                    idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so tx/ra/busy/done never glitch.
    always_comb begin
        shift_d = (state_q == S_FETCH) ? rd :
                  (state_q == S_DATA && tick && !enter) ? shift_q >> 1 : shift_q;
        bit_d   = enter ? '0 : (state_q == S_DATA && tick) ? bit_q + 1'b1 : bit_q;
        ra_d    = (state_d == S_FETCH && enter) ? idx_d : (state_q == S_DONE) ? '0 : ra_q;
        tx_d    = (state_d == S_START) ? START_BIT : (state_d == S_DATA) ? shift_d[0] : STOP_BIT;
        busy_d  = state_d != S_IDLE;
        done_d  = state_d == S_DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ra_q    <= '0;
            tx_q    <= STOP_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ra_q    <= ra_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign ra   = ra_q;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: randomized dumps of a modelled register bank, frames decoded off tx and scoreboarded.
module tb_reg_dump_tx;
    logic       clk, rst, start, tx, busy, done;
    logic [2:0] ra;
    logic [7:0] rd;
    logic [7:0] bank [8];
    logic [7:0] exp_q [$];
    int         n_cmp = 0, n_err = 0, n_dumps = 0, mon_frames = 0;
    bit         mon_en = 0;

    assign rd = bank[ra];

    reg_dump_tx #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .CLKS_PER_BIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .ra   (ra),
        .rd   (rd),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One dump = 8 frames of 41 cycles plus the done cycle; n counts negedges after the accepting edge.
    task automatic dump(input int w, input bit poke, input bit samp, input bit drop);
        int done_at = 0;
        int done_cnt = 0;
        start = 1;
        for (int n = 1; n <= 330; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("busy_rise", busy, 1);
                chk("tx_fetch_idle", tx, 1);
                for (int k = 0; k < 8; k++) exp_q.push_back(bank[k]);
                n_dumps++;
            end
            if (n == 2) chk("tx_fall", tx, 0);
            if (n % 41 == 1 && n < 329) chk("ra_fetch", ra, (n - 1) / 41);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (n == w) start = 0;
            if (poke && n == 90) start = 1;
            if (poke && n == 95) start = 0;
            if (poke && n == 329) start = 1;
            if (samp && n == 125) bank[3] = 8'hA5;
            if (drop && n == 329) start = 0;
            if (n == 330) begin
                chk("busy_fall", busy, 0);
                chk("done_low", done, 0);
                chk("ra_after_done", ra, 0);
                if (poke) start = 0;
            end
        end
        chk("done_latency", done_at, 329);
        chk("done_count", done_cnt, 1);
        if (samp) bank[3] = 8'h33;
    endtask

    initial begin
        logic [7:0] b;
        bit         ok, pend;
        logic       g1, g2;
        pend = 0;
        wait (mon_en);
        forever begin
            if (!pend) do @(negedge clk); while (tx !== 1'b0);
            pend = 0;
            ok = 1;
            repeat (3) begin
                @(negedge clk);
                if (tx !== 1'b0) ok = 0;
            end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                b[i] = tx;
                repeat (3) begin
                    @(negedge clk);
                    if (tx !== b[i]) ok = 0;
                end
            end
            repeat (4) begin
                @(negedge clk);
                if (tx !== 1'b1) ok = 0;
            end
            chk("bit_hold", ok, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got %02h expected none", b);
            end else chk("frame_data", b, exp_q.pop_front());
            mon_frames++;
            if (mon_frames % 8 != 0) begin
                @(negedge clk);
                g1 = tx;
                @(negedge clk);
                g2 = tx;
                chk("frame_gap", {g1, g2}, 2'b10);
                pend = (g2 === 1'b0);
            end
        end
    end

    initial begin
        int w;
        rst = 1;
        start = 0;
        for (int k = 0; k < 8; k++) bank[k] = 8'(k * 8'h11);
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ra", ra, 0);
        rst = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (132) @(negedge clk);
        chk("ra_pre_rst", ra, 3);
        #3 rst = 1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ra", ra, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 0;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1);
            chk("post_rst_busy", busy, 0);
        end
        mon_en = 1;
        @(negedge clk);
        dump(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        dump(1, 0, 1, 0);
        repeat (2) @(negedge clk);
        dump(1, 1, 0, 0);
        repeat (20) begin
            @(negedge clk);
            chk("ignored_start_busy", busy, 0);
        end
        dump(0, 0, 0, 0);
        dump(0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) bank[k] = 8'($urandom);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            w = $urandom_range(1, 3);
            dump(w, 0, 0, 0);
        end
        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_total", mon_frames, 8 * n_dumps);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
